// File: rtl/dmem_arb_pkg.sv
// Package: dmem_arb_pkg
//
// Shared types and helpers for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   dmem_req_t  : request captured at the moment it is accepted
//   SIZE_B*     : the legal transfer sizes in bytes
//   size_ok()   : legality check (size, alignment, range) made at accept
//   size_mask() : mask that keeps only the low size*8 bits of load data
//
// Optional feature macro used by the files importing this package:
//   DMEM_ARB_ROUND_ROBIN_EN

package dmem_arb_pkg;

  localparam int DATA_W = 64;
  localparam int PORT_W = 8;

  localparam logic [3:0] SIZE_B1 = 4'd1;
  localparam logic [3:0] SIZE_B2 = 4'd2;
  localparam logic [3:0] SIZE_B4 = 4'd4;
  localparam logic [3:0] SIZE_B8 = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        size;
    logic [PORT_W-1:0] port;
  } dmem_req_t;

  // The end address is formed one bit wider than the address so that a
  // request near the top of the 64-bit space cannot wrap into range.
  function automatic logic size_ok(input logic [3:0]        size,
                                   input logic [DATA_W-1:0] addr,
                                   input int unsigned       mem_bytes);
    logic            legal;
    logic            aligned;
    logic            in_range;
    logic [DATA_W:0] end_addr;
    legal    = (size == SIZE_B1) || (size == SIZE_B2) ||
               (size == SIZE_B4) || (size == SIZE_B8);
    aligned  = ((addr & DATA_W'(size - 4'd1)) == '0);
    end_addr = {1'b0, addr} + (DATA_W+1)'(size);
    in_range = (end_addr <= (DATA_W+1)'(mem_bytes));
    return legal && aligned && in_range;
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [3:0] size);
    logic [DATA_W-1:0] mask;
    case (size)
      SIZE_B1: mask = 64'h0000_0000_0000_00FF;
      SIZE_B2: mask = 64'h0000_0000_0000_FFFF;
      SIZE_B4: mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Module: dmem_rr_pick
//
// Combinational request picker for the data-memory arbiter. Searches the
// request vector starting at the pointer and wrapping around, and returns
// the first requester found.
//
// Ports:
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  search start index
//   grant out NREQ   one-hot grant (zero when nobody requests)
//   idx   out IDX_W  index of the granted requester
//   any   out 1      at least one requester present
//
// Macro: DMEM_ARB_ROUND_ROBIN_EN. When undefined the pointer is ignored
// and the search always starts at 0, giving fixed lowest-index priority.

module dmem_rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] start;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  assign start = ptr;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`endif

  // Walk NREQ candidates from the start index; the sum is kept one bit
  // wider so the wrap works for port counts that are not a power of two.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, start} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Module: dmem_arbiter
//
// Shares one single-port, byte-addressed, little-endian data memory among
// NREQ requesters (port 0 = CPU load/store unit, port 1 = debug/DMA loader).
// One access is in flight at a time: IDLE -> ACCESS -> RESP -> IDLE, or
// IDLE -> RESP for a request rejected on size, alignment or range.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [NREQ]   request handshake per port
//   req_write [NREQ]             1 = store, 0 = load
//   req_addr/req_wdata [NREQ*64] per-port address and store data
//   req_size [NREQ*4]            transfer size in bytes (1/2/4/8)
//   rsp_valid/rsp_ready [NREQ]   response handshake per port
//   rsp_rdata [64], rsp_err      shared response payload
//   mem_*                        drive to / data from the memory
//
// Macro: DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; without
// it the lowest-index requester always wins.

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*ADDR_W-1:0] req_wdata,
  input  logic [NREQ*4-1:0]      req_size,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [ADDR_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_write_enable,
  output logic                   mem_read_enable,
  output logic [ADDR_W-1:0]      mem_write_data,
  output logic [3:0]             mem_xfer_size,
  input  logic [ADDR_W-1:0]      mem_read_data
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t state;
  arb_state_t state_next;
  dmem_req_t  req_q;

  logic [ADDR_W-1:0] rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [ADDR_W-1:0] wdata_arr [NREQ];
  logic [3:0]        size_arr  [NREQ];

  logic [NREQ-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [IDX_W-1:0]  rr_ptr;

  logic              accept;
  logic              sel_ok;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_wdata;
  logic [3:0]        sel_size;
  logic [IDX_W-1:0]  rsp_port;

  for (genvar p = 0; p < NREQ; p++) begin : g_unpack
    assign addr_arr[p]  = req_addr[p*ADDR_W +: ADDR_W];
    assign wdata_arr[p] = req_wdata[p*ADDR_W +: ADDR_W];
    assign size_arr[p]  = req_size[p*4 +: 4];
  end

  dmem_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_write = req_write[pick_idx];
  assign sel_addr  = addr_arr[pick_idx];
  assign sel_wdata = wdata_arr[pick_idx];
  assign sel_size  = size_arr[pick_idx];
  assign sel_ok    = size_ok(sel_size, sel_addr, MEM_BYTES);
  assign accept    = (state == IDLE) && pick_any;

  // Only the low IDX_W bits of the stored port number are meaningful.
  assign rsp_port = req_q.port[IDX_W-1:0];
  logic unused_port_hi;
  assign unused_port_hi = ^req_q.port[PORT_W-1:IDX_W];

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // The port after the one just granted gets first look next time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The accepted request is frozen here so requesters may change their
  // inputs right after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.write <= sel_write;
      req_q.addr  <= sel_addr;
      req_q.wdata <= sel_wdata;
      req_q.size  <= sel_size;
      req_q.port  <= PORT_W'(pick_idx);
    end
  end

  // Rejected requests get their error result at accept; legal loads pick
  // up masked memory data on the edge that ends ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= '0;
      err_q   <= !sel_ok;
    end else if (state == ACCESS) begin
      rdata_q <= req_q.write ? '0 : (mem_read_data & size_mask(req_q.size));
    end
  end

  // Next state plus every state-dependent output. req_ready is also gated
  // by reset_n so the ports see no acceptance while reset is held.
  always_comb begin
    state_next       = state;
    req_ready        = '0;
    rsp_valid        = '0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = '0;
    mem_xfer_size    = SIZE_B8;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready  = pick_grant & {NREQ{reset_n}};
          state_next = sel_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        mem_address      = req_q.addr;
        mem_write_enable = req_q.write;
        mem_read_enable  = !req_q.write;
        mem_write_data   = req_q.write ? req_q.wdata : '0;
        mem_xfer_size    = req_q.size;
        state_next       = RESP;
      end
      RESP: begin
        rsp_valid[rsp_port] = 1'b1;
        if (rsp_ready[rsp_port]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign rsp_err   = (state == RESP) ? err_q : 1'b0;

`ifndef SYNTHESIS
  // A waiting requester must keep its request unchanged until accepted.
  for (genvar p = 0; p < NREQ; p++) begin : g_hold_check
    a_req_hold: assert property (@(posedge clk) disable iff (!reset_n)
      (req_valid[p] && !req_ready[p]) |=>
        (req_valid[p] && $stable(req_write[p]) && $stable(addr_arr[p]) &&
         $stable(wdata_arr[p]) && $stable(size_arr[p])));
  end
`endif

endmodule
